pc_branch_unit: RTL
===================

# pc_branch_unit

Fetch-side control stage that owns the program counter and feeds the `instruction_memory` address port. It replaces the free-running PC counter. It registers the ALU flags (Z, N, C, V) and resolves jump, call, return and halt instructions from the fetched 16-bit word, so branch decisions use flags from earlier instructions.

## Interface
Parameters:
- `STACK_DEPTH`, 4 — return-address stack entries (only with `PCBU_CALL_STACK_EN`; power of two, 2–16).
- `PC_RESET`, 8'h00 — PC value on reset.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `instr`  in  16  — current word from instruction memory; opcode = `instr[15:9]`, K = `instr[7:0]`.
- `alu_z`, `alu_n`, `alu_c`, `alu_v`  in  1 each — combinational ALU flags.
- `flag_we`  in  1 — decoder asserts for flag-writing ALU ops.
- `stall`  in  1 — freeze PC, flags, stack and state this cycle.
- `pc`  out  8 — instruction memory address.
- `flags_q`  out  4 — registered {V,C,N,Z}.
- `branch_taken`  out  1 — combinational; current instruction redirects PC.
- `halted`  out  1 — registered; core is in HALT.
- `stk_err`  out  1 — sticky stack overflow/underflow.

## Operation
- Opcode group `instr[15:13]==3'b101` is a conditional jump. Condition `instr[12:9]`:
  - 0 JMP (always)
  - 1 JEQ (Z)
  - 2 JNE (!Z)
  - 3 JGT (!N&!Z)
  - 4 JGE (!N)
  - 5 JLT (N)
  - 6 JLE (N|Z)
  - 7 JCS (C)
  - 8 JVS (V)
  - Codes 9–15 are never taken.
- Conditions are evaluated on `flags_q`, never on the live ALU flags.
- Opcode 7'b1100000 is CALL K; 7'b1100001 is RET; 7'b1111111 is HLT.
- Every other opcode falls through.
- Next PC:
  - Jump taken: K.
  - RET with a valid pop: the popped entry.
  - Otherwise: pc+1, modulo 256 (8'hFF → 8'h00).
- When `flag_we`=1, `flags_q` loads {alu_v, alu_c, alu_n, alu_z}. Otherwise it holds.
- State machine:
  - RUN → HALT when HLT is fetched and `stall`=0. PC stays at the HLT address.
  - HALT → RUN only on reset.
  - In HALT: pc, flags, stack and `stk_err` are frozen, and `branch_taken`=0.
- `stall`=1 overrides everything except reset. `branch_taken` is still reported combinationally.

## Timing
- Reset values:
  - pc=`PC_RESET`, flags_q=0, halted=0, stk_err=0, stack pointer=0, state=RUN.
  - `branch_taken` is combinational; it is 0 under reset only if `instr` decodes as non-branch.
- Latency: branch target appears on `pc` one clock after the jump word is presented. There are no delay slots and no bubbles.
- Flag/branch ordering: a flag write and a jump evaluation in the same cycle is impossible, because jump opcodes never assert `flag_we`. If `flag_we` is asserted anyway, the jump uses the pre-update `flags_q`.
- An ALU op at address n writes the flags that a jump at address n+1 sees.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The first fetch after deassertion is at `PC_RESET`.

## Configuration
`PCBU_CALL_STACK_EN`:
- Defined:
  - The return stack has `STACK_DEPTH` entries.
  - CALL pushes pc+1 (wrapped) and jumps to K.
  - CALL when full: jumps to K, drops the push, sets `stk_err`.
  - RET pops into PC.
  - RET when empty: falls through to pc+1 and sets `stk_err`.
  - `branch_taken`=1 for CALL and for a RET with a valid pop.
- Undefined: CALL and RET behave as NOP (pc+1), no stack storage exists, and `stk_err` is tied 0.

## Structure
- Shared package/include `cpu_defs` holds:
  - opcode constants, including the existing ALU opcodes 7'b0000000–7'b0100100 and JMP group, CALL, RET, HLT;
  - condition-code constants;
  - flag bit indices (Z=0, N=1, C=2, V=3).
- One sub-module, `return_stack`: an LIFO of 8-bit entries with `push`, `pop`, `full`, `empty` and async active-low reset. It is instantiated only under `PCBU_CALL_STACK_EN`.

## Test plan
- Sequential fetch and wrap: reset, no branches, 257 clocks → pc goes 0x00…0xFF, then 0x00; `branch_taken`=0 throughout.
- Conditional jumps: `flag_we`=1 with Z=1, N=0; next cycle JEQ 0x40 → pc=0x40. JNE 0x80 at 0x40 → pc=0x41. Repeat all nine codes for both flag polarities.
- Stall and flag hold: at pc=0x10, `stall`=1 for 3 cycles with `flag_we`=1 → pc stays 0x10 and `flags_q` is unchanged; releasing stall gives pc=0x11.
- Stack (with macro, depth 4):
  - CALL 0x20 from 0x05 → pc=0x20; RET → pc=0x06.
  - Five nested CALLs → fifth jumps and `stk_err`=1.
  - RET on empty stack from 0x30 → pc=0x31 and `stk_err`=1.
- Halt and reset: HLT at 0x07 → `halted`=1 and pc stays 0x07 for 10 cycles. Asserting `rst_n` low mid-cycle → pc=0x00, `halted`=0, `flags_q`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, condition codes, flag bit positions and
// the jump-condition evaluator used by the fetch-side control stage.
package cpu_defs;

    localparam int unsigned OPW = 7;

    // ALU opcode range already used by the datapath decoder
    localparam logic [OPW-1:0] OP_ALU_FIRST = 7'b0000000;
    localparam logic [OPW-1:0] OP_ALU_LAST  = 7'b0100100;

    localparam logic [2:0]     JMP_GRP = 3'b101;
    localparam logic [OPW-1:0] OP_CALL = 7'b1100000;
    localparam logic [OPW-1:0] OP_RET  = 7'b1100001;
    localparam logic [OPW-1:0] OP_HLT  = 7'b1111111;

    localparam logic [3:0] CC_JMP = 4'd0;
    localparam logic [3:0] CC_JEQ = 4'd1;
    localparam logic [3:0] CC_JNE = 4'd2;
    localparam logic [3:0] CC_JGT = 4'd3;
    localparam logic [3:0] CC_JGE = 4'd4;
    localparam logic [3:0] CC_JLT = 4'd5;
    localparam logic [3:0] CC_JLE = 4'd6;
    localparam logic [3:0] CC_JCS = 4'd7;
    localparam logic [3:0] CC_JVS = 4'd8;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pcbu_state_e;

    // Codes 9-15 are reserved and never taken.
    function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] f);
        logic z, n, c, v;
        z = f[FLAG_Z];
        n = f[FLAG_N];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc)
            CC_JMP:  return 1'b1;
            CC_JEQ:  return z;
            CC_JNE:  return !z;
            CC_JGT:  return !n && !z;
            CC_JGE:  return !n;
            CC_JLT:  return n;
            CC_JLE:  return n || z;
            CC_JCS:  return c;
            CC_JVS:  return v;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push when full and pop when empty are ignored;
// the caller decides how to report them.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   sp;
    logic [AW-1:0] top_idx;

    assign top_idx = AW'(sp - (AW+1)'(1));
    assign dout    = mem[top_idx];
    assign full    = (sp == (AW+1)'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
            sp <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner: registers ALU flags and resolves jump/call/ret/halt.
// Build macro PCBU_CALL_STACK_EN enables the return stack for CALL/RET.
module pc_branch_unit
    import cpu_defs::*;
#(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [7:0]  PC_RESET    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        flag_we,
    input  logic        stall,
    output logic [7:0]  pc,
    output logic [3:0]  flags_q,
    output logic        branch_taken,
    output logic        halted,
    output logic        stk_err
);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_branch_unit: STACK_DEPTH must be a power of two in 2..16");
    end

    pcbu_state_e     state, state_d;
    logic [OPW-1:0]  opcode;
    logic [3:0]      cc;
    logic [7:0]      k, pc_inc, pc_d, stk_top;
    logic            is_jmp, is_hlt, jmp_taken, run, adv;
    logic            call_redir, ret_redir;
    logic            unused_instr_b8;

    assign opcode          = instr[15:9];
    assign cc              = instr[12:9];
    assign k               = instr[7:0];
    assign unused_instr_b8 = instr[8];

    assign is_jmp    = (instr[15:13] == JMP_GRP);
    assign is_hlt    = (opcode == OP_HLT);
    // Registered flags only: a flag write in this cycle is not yet visible.
    assign jmp_taken = is_jmp && cond_met(cc, flags_q);
    assign run       = (state == ST_RUN);
    assign adv       = run && !stall;
    assign pc_inc    = pc + 8'd1;

`ifdef PCBU_CALL_STACK_EN
    logic is_call, is_ret, stk_full, stk_empty, stk_push, stk_pop;

    assign is_call    = (opcode == OP_CALL);
    assign is_ret     = (opcode == OP_RET);
    assign stk_push   = adv && is_call && !stk_full;
    assign stk_pop    = adv && is_ret && !stk_empty;
    assign call_redir = is_call;
    assign ret_redir  = is_ret && !stk_empty;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (8)
    ) u_rstk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stk_err <= 1'b0;
        else if (adv && ((is_call && stk_full) || (is_ret && stk_empty)))
            stk_err <= 1'b1;
    end
`else
    assign call_redir = 1'b0;
    assign ret_redir  = 1'b0;
    assign stk_top    = '0;
    assign stk_err    = 1'b0;
`endif

    assign branch_taken = run && (jmp_taken || call_redir || ret_redir);

    always_comb begin
        pc_d = pc;
        if (adv && !is_hlt) begin
            if (jmp_taken || call_redir) pc_d = k;
            else if (ret_redir)          pc_d = stk_top;
            else                         pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_RESET;
            flags_q <= '0;
        end else begin
            pc <= pc_d;
            if (adv && flag_we) flags_q <= {alu_v, alu_c, alu_n, alu_z};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_d;
    end

    // HALT is left only through reset.
    always_comb begin
        state_d = state;
        if (state == ST_RUN && !stall && is_hlt) state_d = ST_HALT;
    end

    always_comb begin
        halted = (state == ST_HALT);
    end

endmodule
